// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: ID-side and EX-side handshake/operand bundle of the ALU issue register
interface alu_issue_stage_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [5:0]       funct;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic [WIDTH-1:0] imm;
  logic             alu_src;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_control;
  logic             illegal;
  modport slave (
    input  in_valid, alu_op, funct, rs_data, rt_data, imm, alu_src, flush, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_control, illegal
  );
  modport master (
    output in_valid, alu_op, funct, rs_data, rt_data, imm, alu_src, flush, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_control, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: one-entry ID/EX register decoding ALUOp+funct and selecting operand b; ALU_ILLEGAL_COUNT_EN adds illegal_count
module alu_issue_stage #(
  parameter int WIDTH = 32
`ifdef ALU_ILLEGAL_COUNT_EN
  , parameter int CNT_WIDTH = 8
`endif
) (
  input logic clk,
  input logic reset,
  alu_issue_stage_if.slave bus
`ifdef ALU_ILLEGAL_COUNT_EN
  , output logic [CNT_WIDTH-1:0] illegal_count
`endif
);
  logic             valid_q, valid_d, illegal_q, illegal_d, load, dec_illegal;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       ctrl_q, ctrl_d, funct_code, dec_code;
  assign bus.in_ready = !valid_q || bus.out_ready;
  always_comb begin
    funct_code  = bus.funct == 6'b100000 ? 3'b010 :
                  bus.funct == 6'b100010 ? 3'b110 :
                  bus.funct == 6'b100100 ? 3'b000 :
                  bus.funct == 6'b100101 ? 3'b001 :
                  bus.funct == 6'b101010 ? 3'b111 : 3'b011;
    dec_code    = bus.alu_op == 2'b00 ? 3'b010 :
                  bus.alu_op == 2'b01 ? 3'b110 :
                  bus.alu_op == 2'b10 ? funct_code : 3'b011;
    dec_illegal = dec_code == 3'b011;
    load        = bus.in_valid && bus.in_ready && !bus.flush;
    valid_d     = bus.flush ? 1'b0 : load ? 1'b1 : valid_q && !bus.out_ready;
    a_d         = load ? bus.rs_data : a_q;
    b_d         = load ? (bus.alu_src ? bus.imm : bus.rt_data) : b_q;
    ctrl_d      = load ? dec_code : ctrl_q;
    illegal_d   = !valid_d ? 1'b0 : load ? dec_illegal : illegal_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      ctrl_q    <= 3'b011;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      a_q       <= a_d;
      b_q       <= b_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end
  assign bus.out_valid   = valid_q;
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.alu_control = ctrl_q;
  assign bus.illegal     = illegal_q;
`ifdef ALU_ILLEGAL_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load && dec_illegal && !(&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign illegal_count = cnt_q;
`endif
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: randomized and directed checks of alu_issue_stage against a behavioural model
module tb_alu_issue_stage;
  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total = 0;
  alu_issue_stage_if #(.WIDTH(32)) bus ();
`ifdef ALU_ILLEGAL_COUNT_EN
  logic [7:0] illegal_count;
  alu_issue_stage dut (.clk(clk), .reset(reset), .bus(bus), .illegal_count(illegal_count));
`else
  alu_issue_stage dut (.clk(clk), .reset(reset), .bus(bus));
`endif
  always #5 clk = ~clk;
  logic        m_valid = 1'b0;
  logic [31:0] m_a = '0, m_b = '0;
  logic [2:0]  m_ctrl = 3'b011;
  logic        m_ill = 1'b0;
  int          m_cnt = 0;
  function automatic logic [2:0] ref_code(input logic [1:0] op, input logic [5:0] f);
    case (op)
      2'd0: return 3'b010;
      2'd1: return 3'b110;
      2'd2:
        case (f)
          6'd32:   return 3'b010;
          6'd34:   return 3'b110;
          6'd36:   return 3'b000;
          6'd37:   return 3'b001;
          6'd42:   return 3'b111;
          default: return 3'b011;
        endcase
      default: return 3'b011;
    endcase
  endfunction
  task automatic cycle();
    logic rdy;
    @(posedge clk);
    rdy = !m_valid || bus.out_ready;
    if (reset) begin
      m_valid = 0; m_a = 0; m_b = 0; m_ctrl = 3'b011; m_ill = 0; m_cnt = 0;
    end else if (bus.flush) begin
      m_valid = 0; m_ill = 0;
    end else if (bus.in_valid && rdy) begin
      m_valid = 1;
      m_a = bus.rs_data;
      m_b = bus.alu_src ? bus.imm : bus.rt_data;
      m_ctrl = ref_code(bus.alu_op, bus.funct);
      m_ill = m_ctrl == 3'b011;
      if (m_ill && m_cnt < 255) m_cnt++;
    end else if (bus.out_ready) begin
      m_valid = 0; m_ill = 0;
    end
    #1;
  endtask
  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [31:0] im, input logic src, input logic fl, input logic ordy);
    bus.in_valid = v; bus.alu_op = op; bus.funct = f; bus.rs_data = rs; bus.rt_data = rt;
    bus.imm = im; bus.alu_src = src; bus.flush = fl; bus.out_ready = ordy;
    #1;
  endtask
  task automatic test_reset();
    drive(1, 2'd2, 6'd32, 32'd5, 32'd6, 32'd0, 0, 0, 1);
    reset = 1;
    cycle();
    cycle();
    reset = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); else passed++;
    total++; if (bus.alu_control !== 3'b011) $display("FAIL reset_alu_control got %b want 011", bus.alu_control); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); else passed++;
    total++; if ({bus.alu_a, bus.alu_b, bus.illegal} !== 65'd0) $display("FAIL reset_data got %h %h %0b want 0", bus.alu_a, bus.alu_b, bus.illegal); else passed++;
  endtask
  task automatic test_sub();
    drive(1, 2'd2, 6'b100010, 32'd7, 32'd3, 32'd99, 0, 0, 1);
    cycle();
    total++;
    if ({bus.out_valid, bus.alu_a, bus.alu_b, bus.alu_control, bus.illegal} !== {1'b1, 32'd7, 32'd3, 3'b110, 1'b0})
      $display("FAIL sub_load got v=%0b a=%0d b=%0d c=%b want v=1 a=7 b=3 c=110", bus.out_valid, bus.alu_a, bus.alu_b, bus.alu_control);
    else passed++;
  endtask
  task automatic test_hold();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle();
    drive(1, 2'd0, 6'd0, 32'd100, 32'd1, 32'hFFFF_FFFC, 1, 0, 0);
    cycle();
    drive(1, 2'd2, 6'b100000, 32'd1, 32'd2, 32'd0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.in_ready !== 1'b0) $display("FAIL hold_in_ready cyc %0d got %0b want 0", i, bus.in_ready); else passed++;
      cycle();
      total++;
      if ({bus.out_valid, bus.alu_a, bus.alu_b, bus.alu_control} !== {1'b1, 32'd100, 32'hFFFF_FFFC, 3'b010})
        $display("FAIL hold_stable cyc %0d got v=%0b a=%0d b=%h c=%b want v=1 a=100 b=fffffffc c=010", i, bus.out_valid, bus.alu_a, bus.alu_b, bus.alu_control);
      else passed++;
    end
    bus.out_ready = 1; #1;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL release_in_ready got %0b want 1", bus.in_ready); else passed++;
    cycle();
    total++;
    if ({bus.out_valid, bus.alu_a, bus.alu_b} !== {1'b1, 32'd1, 32'd2})
      $display("FAIL second_beat got v=%0b a=%0d b=%0d want v=1 a=1 b=2", bus.out_valid, bus.alu_a, bus.alu_b);
    else passed++;
  endtask
  task automatic test_flush();
    drive(1, 2'd2, 6'b100100, 32'd55, 32'd56, 32'd0, 0, 1, 0);
    cycle();
    total++;
    if ({bus.out_valid, bus.alu_a} !== {1'b0, 32'd1})
      $display("FAIL flush_held got v=%0b a=%0d want v=0 a=1", bus.out_valid, bus.alu_a);
    else passed++;
    drive(1, 2'd2, 6'b100101, 32'd9, 32'd10, 32'd0, 0, 0, 1);
    cycle();
    drive(1, 2'd2, 6'b100000, 32'd77, 32'd78, 32'd0, 0, 1, 1);
    total++; if (bus.in_ready !== 1'b1) $display("FAIL flush_in_ready got %0b want 1", bus.in_ready); else passed++;
    cycle();
    total++;
    if ({bus.out_valid, bus.alu_a, bus.alu_b, bus.alu_control} !== {1'b0, 32'd9, 32'd10, 3'b001})
      $display("FAIL flush_wins got v=%0b a=%0d b=%0d c=%b want v=0 a=9 b=10 c=001", bus.out_valid, bus.alu_a, bus.alu_b, bus.alu_control);
    else passed++;
  endtask
  task automatic test_illegal();
    drive(1, 2'd2, 6'b000000, 32'd4, 32'd5, 32'd0, 0, 0, 1);
    cycle();
    total++;
    if ({bus.out_valid, bus.alu_control, bus.illegal} !== {1'b1, 3'b011, 1'b1})
      $display("FAIL illegal_funct got v=%0b c=%b ill=%0b want v=1 c=011 ill=1", bus.out_valid, bus.alu_control, bus.illegal);
    else passed++;
    drive(1, 2'd3, 6'b100000, 32'd4, 32'd5, 32'd0, 0, 0, 1);
    cycle();
    total++;
    if ({bus.alu_control, bus.illegal} !== {3'b011, 1'b1})
      $display("FAIL illegal_op11 got c=%b ill=%0b want c=011 ill=1", bus.alu_control, bus.illegal);
    else passed++;
`ifdef ALU_ILLEGAL_COUNT_EN
    drive(1, 2'd2, 6'b000000, 32'd4, 32'd5, 32'd0, 0, 0, 1);
    for (int i = 0; i < 300; i++) cycle();
    total++; if (illegal_count !== 8'd255) $display("FAIL illegal_count_sat got %0d want 255", illegal_count); else passed++;
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle();
    total++;
    if ({bus.out_valid, bus.illegal, bus.alu_control} !== {1'b0, 1'b0, 3'b011})
      $display("FAIL illegal_drain got v=%0b ill=%0b c=%b want v=0 ill=0 c=011", bus.out_valid, bus.illegal, bus.alu_control);
    else passed++;
  endtask
  task automatic test_back_to_back();
    logic [5:0] fs [4] = '{6'b100000, 6'b100010, 6'b100100, 6'b101010};
    logic [2:0] cs [4] = '{3'b010, 3'b110, 3'b000, 3'b111};
    for (int i = 0; i < 4; i++) begin
      drive(1, 2'd2, fs[i], 32'(i + 20), 32'(i + 30), 32'd0, 0, 0, 1);
      cycle();
      total++;
      if ({bus.out_valid, bus.alu_control, bus.alu_a} !== {1'b1, cs[i], 32'(i + 20)})
        $display("FAIL stream beat %0d got v=%0b c=%b a=%0d want v=1 c=%b a=%0d", i, bus.out_valid, bus.alu_control, bus.alu_a, cs[i], i + 20);
      else passed++;
    end
  endtask
  task automatic test_random();
    logic [5:0] legal [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
            $urandom_range(0, 3) != 0 ? legal[$urandom_range(0, 4)] : 6'($urandom),
            $urandom, $urandom, $urandom, 1'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6);
      total++;
      if (bus.in_ready !== (!m_valid || bus.out_ready)) $display("FAIL rand_in_ready cyc %0d got %0b want %0b", i, bus.in_ready, !m_valid || bus.out_ready);
      else passed++;
      cycle();
      total++;
      if ({bus.out_valid, bus.alu_a, bus.alu_b, bus.alu_control, bus.illegal} !== {m_valid, m_a, m_b, m_ctrl, m_ill})
        $display("FAIL rand_out cyc %0d got v=%0b a=%h b=%h c=%b ill=%0b want v=%0b a=%h b=%h c=%b ill=%0b", i,
                 bus.out_valid, bus.alu_a, bus.alu_b, bus.alu_control, bus.illegal, m_valid, m_a, m_b, m_ctrl, m_ill);
      else passed++;
`ifdef ALU_ILLEGAL_COUNT_EN
      total++; if (illegal_count !== 8'(m_cnt)) $display("FAIL rand_count cyc %0d got %0d want %0d", i, illegal_count, m_cnt); else passed++;
`endif
    end
  endtask
  initial begin
    reset = 0;
    test_reset();
    test_sub();
    test_hold();
    test_flush();
    test_illegal();
    test_back_to_back();
    reset = 1;
    cycle();
    reset = 0;
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout reached before summary");
    $fatal(1, "timeout");
  end
endmodule
